// File: rtl/open_list_pkg.sv
// Shared types for the open-list queue arbitration blocks.
package open_list_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam logic [DEF_DATA_WIDTH-1:0] MAX_VALUE = '1;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_GAP  = 1'b1
  } arb_state_e;

  // Requested queue operation; push together with pop means replace.
  function automatic op_e op_of(input logic push, input logic pop);
    return op_e'({pop, push});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after the pointer.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any_grant
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  // Scan NUM_REQ positions starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, i_rr_ptr} + (ID_W+1)'(off);
      idx = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : ID_W'(sum);
      if (!found && i_eligible[idx]) begin
        found        = 1'b1;
        o_grant_idx  = idx;
        o_grant[idx] = 1'b1;
      end
    end
    o_any_grant = found;
  end

endmodule

// File: rtl/open_list_arbiter.sv
// Shares one systolic min-queue between NUM_REQ requesters with round-robin
// arbitration, legality filtering on full/empty, and a settle gap per op.
module open_list_arbiter
  import open_list_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int          ISSUE_GAP  = 1,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic [NUM_REQ-1:0]            i_req_push,
  input  logic [NUM_REQ-1:0]            i_req_pop,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_rsp_valid,
  output logic [ID_W-1:0]               o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_q_wrt,
  output logic                          o_q_read,
  output logic [DATA_WIDTH-1:0]         o_q_node_f,
  input  logic                          i_q_full,
  input  logic                          i_q_empty,
  input  logic [DATA_WIDTH-1:0]         i_q_node_f,
  output logic                          o_busy
);

  localparam int unsigned GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  arb_state_e            state;
  logic [ID_W-1:0]       rr_ptr;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  rsp_valid_q;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [ID_W-1:0]       gidx;
  logic                  any_grant;
  logic                  issue;
  logic                  sel_push;
  logic                  sel_pop;
  logic [DATA_WIDTH-1:0] sel_data;

  // Legality of each requester's op against the current queue flags.
  always_comb begin
    eligible = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      unique case (op_of(i_req_push[k], i_req_pop[k]))
        OP_PUSH:    eligible[k] = !i_q_full;
        OP_POP:     eligible[k] = !i_q_empty;
        OP_REPLACE: eligible[k] = !i_q_full && !i_q_empty;
        default:    eligible[k] = 1'b0;
      endcase
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_eligible  (eligible),
    .i_rr_ptr    (rr_ptr),
    .o_grant     (arb_grant),
    .o_grant_idx (gidx),
    .o_any_grant (any_grant)
  );

  // Mux the granted requester's op and data onto the queue port.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gidx == ID_W'(k)) sel_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    sel_push   = i_req_push[gidx];
    sel_pop    = i_req_pop[gidx];
    issue      = RSTn && (state == ARB_IDLE) && any_grant;
    o_grant    = issue ? arb_grant : '0;
    o_q_wrt    = issue && sel_push;
    o_q_read   = issue && sel_pop;
    o_q_node_f = issue ? sel_data : '0;
  end

  // Gated by reset so a response registered before a mid-gap reset never surfaces.
  assign o_rsp_valid = rsp_valid_q && RSTn;
  assign o_busy      = (state == ARB_GAP);

  // Issue/gap sequencing, round-robin pointer and pop response capture.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      gap_cnt     <= '0;
      rsp_valid_q <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_data  <= '0;
    end else begin
      rsp_valid_q <= issue && sel_pop;
      if (issue && sel_pop) begin
        o_rsp_id   <= gidx;
        o_rsp_data <= i_q_node_f;
      end
      unique case (state)
        ARB_IDLE: begin
          if (issue) begin
            rr_ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            if (ISSUE_GAP > 0) begin
              state   <= ARB_GAP;
              gap_cnt <= GAP_W'(ISSUE_GAP - 1);
            end
          end
        end
        ARB_GAP: begin
          if (gap_cnt == '0) state <= ARB_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_open_list_arbiter.sv
// Directed bench for open_list_arbiter with a behavioural 8-entry min-queue.
module tb_open_list_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned QCAP = 8;

  logic           CLK = 1'b0;
  logic           RSTn;
  logic [NR-1:0]  req_push;
  logic [NR-1:0]  req_pop;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  grant;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [DW-1:0]  rsp_data;
  logic           q_wrt;
  logic           q_read;
  logic [DW-1:0]  q_node_f_in;
  logic           q_full;
  logic           q_empty;
  logic [DW-1:0]  q_head;
  logic           busy;

  int tests = 0;
  int fails = 0;

  open_list_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ISSUE_GAP(1)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .i_req_push  (req_push),
    .i_req_pop   (req_pop),
    .i_req_data  (req_data),
    .o_grant     (grant),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_data  (rsp_data),
    .o_q_wrt     (q_wrt),
    .o_q_read    (q_read),
    .o_q_node_f  (q_node_f_in),
    .i_q_full    (q_full),
    .i_q_empty   (q_empty),
    .i_q_node_f  (q_head),
    .o_busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Sorted min-queue model; contents and flags change at the issue edge.
  logic [DW-1:0] qm [QCAP];
  int unsigned   qcnt = 0;

  assign q_full  = (qcnt == QCAP);
  assign q_empty = (qcnt == 0);
  assign q_head  = (qcnt != 0) ? qm[0] : '0;

  initial for (int i = 0; i < QCAP; i++) qm[i] = '0;

  always @(posedge CLK) begin
    logic [DW-1:0] t [QCAP];
    int unsigned n;
    int unsigned p;
    t = qm;
    n = qcnt;
    if (q_wrt || q_read) begin
      tests++;
      assert (!(q_wrt && !q_read && n == QCAP) && !(q_read && n == 0) && !(q_wrt && q_read && n == QCAP))
      else begin
        fails++;
        $error("FAIL illegal_op: wrt=%0d read=%0d count=%0d required legal op", q_wrt, q_read, n);
      end
    end
    if (q_read && n > 0) begin
      for (int i = 0; i < QCAP - 1; i++) t[i] = t[i+1];
      n--;
    end
    if (q_wrt && n < QCAP) begin
      p = n;
      while (p > 0 && t[p-1] > q_node_f_in) begin
        t[p] = t[p-1];
        p--;
      end
      t[p] = q_node_f_in;
      n++;
    end
    qm   <= t;
    qcnt <= n;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int unsigned exp_id [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  logic [DW-1:0] exp_d [8] = '{32'd1, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd100};
  logic [NR-1:0] one = 4'b0001;

  initial begin
    RSTn = 1'b0;
    req_push = '0;
    req_pop  = '0;
    req_data = '0;
    req_push[0] = 1'b1;
    req_data[0*DW +: DW] = 32'd7;
    tick(); tick(); #1;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_wrt", 64'(q_wrt), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_id", 64'(rsp_id), 64'h0);
    chk("rst_rsp_data", 64'(rsp_data), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    // Two pushes, one gap cycle between them
    tick(); RSTn = 1'b1; req_push[1] = 1'b1; req_data[1*DW +: DW] = 32'd3; #1;
    chk("push0_grant", 64'(grant), 64'h1);
    chk("push0_wrt", 64'(q_wrt), 64'h1);
    chk("push0_node", 64'(q_node_f_in), 64'd7);
    chk("push0_busy", 64'(busy), 64'h0);
    tick(); req_push[0] = 1'b0; #1;
    chk("gap1_grant", 64'(grant), 64'h0);
    chk("gap1_busy", 64'(busy), 64'h1);
    tick(); #1;
    chk("push1_grant", 64'(grant), 64'h2);
    chk("push1_node", 64'(q_node_f_in), 64'd3);
    tick(); req_push[1] = 1'b0; #1;
    chk("gap2_busy", 64'(busy), 64'h1);

    // Pops return the minimum first
    tick(); req_pop[2] = 1'b1; #1;
    chk("pop2_grant", 64'(grant), 64'h4);
    chk("pop2_read", 64'(q_read), 64'h1);
    chk("pop2_wrt", 64'(q_wrt), 64'h0);
    tick(); req_pop[2] = 1'b0; #1;
    chk("pop2_valid", 64'(rsp_valid), 64'h1);
    chk("pop2_id", 64'(rsp_id), 64'd2);
    chk("pop2_data", 64'(rsp_data), 64'd3);
    tick(); req_pop[2] = 1'b1; #1;
    chk("pulse_valid", 64'(rsp_valid), 64'h0);
    chk("pop2b_grant", 64'(grant), 64'h4);
    tick(); req_pop[2] = 1'b0; #1;
    chk("pop2b_valid", 64'(rsp_valid), 64'h1);
    chk("pop2b_data", 64'(rsp_data), 64'd7);

    // Pop on empty queue is skipped, push proceeds
    tick(); req_pop[0] = 1'b1; req_push[1] = 1'b1; req_data[1*DW +: DW] = 32'd9; #1;
    chk("skip_grant", 64'(grant), 64'h2);
    chk("skip_read", 64'(q_read), 64'h0);
    tick(); req_push[1] = 1'b0; #1;
    chk("skip_gap_grant", 64'(grant), 64'h0);
    tick(); #1;
    chk("late_pop_grant", 64'(grant), 64'h1);
    tick(); req_pop[0] = 1'b0; #1;
    chk("late_pop_id", 64'(rsp_id), 64'd0);
    chk("late_pop_data", 64'(rsp_data), 64'd9);

    // Fill queue with 9..2
    for (int v = 9; v >= 2; v--) begin
      tick(); req_push[0] = 1'b1; req_data[0*DW +: DW] = 32'(v); #1;
      chk("fill_grant", 64'(grant), 64'h1);
      tick(); req_push[0] = 1'b0; #1;
    end

    // Full queue: pushes and replace both blocked
    tick();
    req_push = 4'b1111; req_pop[3] = 1'b1;
    req_data[0*DW +: DW] = 32'd100;
    req_data[1*DW +: DW] = 32'd101;
    req_data[2*DW +: DW] = 32'd102;
    req_data[3*DW +: DW] = 32'd1;
    #1;
    chk("full_grant", 64'(grant), 64'h0);
    chk("full_wrt", 64'(q_wrt), 64'h0);
    chk("full_node", 64'(q_node_f_in), 64'h0);
    chk("full_busy", 64'(busy), 64'h0);
    tick(); #1;
    chk("full_grant2", 64'(grant), 64'h0);
    tick(); req_push[2:0] = 3'b000; req_pop[2] = 1'b1; #1;
    chk("full_pop_grant", 64'(grant), 64'h4);
    tick(); req_pop[2] = 1'b0; req_push[0] = 1'b1; #1;
    chk("full_pop_data", 64'(rsp_data), 64'd2);
    chk("full_pop_id", 64'(rsp_id), 64'd2);
    tick(); #1;
    chk("repl_grant", 64'(grant), 64'h8);
    chk("repl_wrt", 64'(q_wrt), 64'h1);
    chk("repl_read", 64'(q_read), 64'h1);
    chk("repl_node", 64'(q_node_f_in), 64'd1);
    tick(); req_push[3] = 1'b0; req_pop[3] = 1'b0; #1;
    chk("repl_valid", 64'(rsp_valid), 64'h1);
    chk("repl_id", 64'(rsp_id), 64'd3);
    chk("repl_data", 64'(rsp_data), 64'd3);
    tick(); #1;
    chk("refill_grant", 64'(grant), 64'h1);
    tick(); req_push[0] = 1'b0; #1;
    chk("push_no_rsp", 64'(rsp_valid), 64'h0);

    // All requesters pop continuously: rotation and sorted drain
    tick(); req_pop = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rot_grant", 64'(grant), 64'(one << exp_id[i]));
      tick(); #1;
      chk("rot_valid", 64'(rsp_valid), 64'h1);
      chk("rot_id", 64'(rsp_id), 64'(exp_id[i]));
      chk("rot_data", 64'(rsp_data), 64'(exp_d[i]));
      tick();
    end
    #1;
    chk("empty_grant", 64'(grant), 64'h0);
    req_pop = '0;

    // Reset in gap after a pop drops the response and clears the pointer
    tick(); req_push[1] = 1'b1; req_data[1*DW +: DW] = 32'd42; #1;
    chk("pre_rst_push", 64'(grant), 64'h2);
    tick(); req_push[1] = 1'b0;
    tick(); req_pop[2] = 1'b1; #1;
    chk("pre_rst_pop", 64'(grant), 64'h4);
    tick(); RSTn = 1'b0; req_pop[2] = 1'b0; #1;
    chk("rst_gap_valid", 64'(rsp_valid), 64'h0);
    chk("rst_gap_grant", 64'(grant), 64'h0);
    tick(); RSTn = 1'b1;
    req_push[1] = 1'b1; req_data[1*DW +: DW] = 32'd50;
    req_push[3] = 1'b1; req_data[3*DW +: DW] = 32'd51;
    #1;
    chk("post_rst_valid", 64'(rsp_valid), 64'h0);
    chk("post_rst_busy", 64'(busy), 64'h0);
    chk("post_rst_id", 64'(rsp_id), 64'h0);
    chk("post_rst_data", 64'(rsp_data), 64'h0);
    chk("post_rst_grant", 64'(grant), 64'h2);
    tick(); req_push = '0; #1;
    chk("post_rst_no_rsp", 64'(rsp_valid), 64'h0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
